mul_sequencer: RTL and testbench

Multi-cycle iterative shift-add multiplier controller that executes MULT/MULTU for the ALU path. It owns the HI/LO register pair. On a start request from decode, it runs WIDTH iterations of shift-add on a private datapath and stalls the pipeline until the product is ready. It also services MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO.

---
 rtl/mul_sequencer_pkg.sv | 16 +
 rtl/mul_sequencer_datapath.sv | 69 ++++++
 rtl/mul_sequencer.sv | 111 +++++++++++
 tb/tb_mul_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_sequencer_pkg.sv
// Shared definitions for the iterative multiply/divide sequencers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mul_sequencer_pkg;

  // Default operand width for the arithmetic sequencers.
  localparam int MUL_WIDTH = 32;

  // Sequencer state encoding, shared with the divide sequencer.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } seq_state_t;

endpackage

// File: rtl/mul_sequencer_datapath.sv
// Shift-add multiply datapath: magnitude capture, WIDTH add/shift steps, sign fix-up.
// Latency: one add/shift per step strobe; the product appears combinationally with step&finish.
// Backpressure: none, fully slaved to the load/step/finish strobes from the sequencer.
//
// Ports: clk/reset (sync, active-high); load captures op_a/op_b/is_signed;
// step performs one iteration; finish marks the last step, raising prod_vld
// with the signed-corrected product on prod_hi/prod_lo.
module mul_shift_add_datapath
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             finish,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             prod_vld,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo
);

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH:0]     acc;
  logic               neg;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] raw;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    // -(2^(WIDTH-1)) wraps to itself, which is the correct unsigned magnitude.
    mag_a = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    mag_b = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
    // acc[WIDTH] is always zero here, so the sum cannot overflow WIDTH+1 bits.
    sum   = acc + (mplier[0] ? {1'b0, mcand} : '0);
    // Low 2*WIDTH bits of {sum, mplier} >> 1: the product after this step.
    raw   = {sum, mplier[WIDTH-1:1]};
    prod  = neg ? -raw : raw;
  end

  assign prod_vld = step & finish;
  assign prod_hi  = prod[2*WIDTH-1:WIDTH];
  assign prod_lo  = prod[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
    end else if (load) begin
      mcand  <= mag_a;
      mplier <= mag_b;
      acc    <= '0;
      neg    <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
    end else if (step) begin
      acc    <= {1'b0, sum[WIDTH:1]};
      mplier <= {sum[0], mplier[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// MULT/MULTU sequencer owning HI/LO; also services MTHI/MTLO writes.
// Latency: start in cycle 0, RUN cycles 1..WIDTH, done pulse and new hi/lo in cycle WIDTH+1.
// Backpressure: stall holds the pipeline from the accepted start through RUN; starts outside IDLE are dropped.
//
// Ports: clk, reset (sync, active-high); start/is_signed/op_a/op_b multiply
// request; hi_we/lo_we/wdata MTHI/MTLO writes (IDLE without start only);
// busy (RUN), done (one-cycle pulse), stall (pipeline hold); hi/lo registers.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [CW-1:0]    count;
  logic             load;
  logic             step;
  logic             finish;
  logic             prod_vld;
  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH-1:0] prod_lo;

  mul_shift_add_datapath #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .finish    (finish),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .prod_vld  (prod_vld),
    .prod_hi   (prod_hi),
    .prod_lo   (prod_lo)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        // count reaching zero marks the WIDTH-th and last iteration.
        if (count == '0) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)                    count <= '0;
    else if (load)                count <= CW'(WIDTH - 1);
    else if (step && count != '0) count <= count - 1'b1;
  end

  assign busy  = (state == RUN);
  assign done  = (state == DONE);
  assign stall = ((state == IDLE) && start) || (state == RUN);

  // A start in IDLE takes priority: same-cycle MTHI/MTLO writes are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (prod_vld) begin
      hi <= prod_hi;
      lo <= prod_lo;
    end else if ((state == IDLE) && !start) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: directed scenarios plus randomized multiplies and HI/LO writes.
// Expected products come from plain 64-bit arithmetic; timing from the documented cycle budget.
module tb_mul_sequencer;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          is_signed;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          hi_we;
  logic          lo_we;
  logic [W-1:0]  wdata;
  logic          busy;
  logic          done;
  logic          stall;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int            ncmp = 0;
  int            nfail = 0;
  logic [W-1:0]  m_hi;
  logic [W-1:0]  m_lo;

  mul_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .stall     (stall),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa;
    longint sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Entered at #1 after a rising edge with the DUT in IDLE. poke (1..W) injects
  // a start plus MTHI/MTLO write in that RUN cycle, all of which must be ignored.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [63:0] exp, input int poke);
    start = 1'b1; op_a = a; op_b = b; is_signed = s;
    @(negedge clk);
    chk($sformatf("%s c0 busy/stall/done", tag), {busy, stall, done}, 3'b010);
    next_cycle();
    op_a = $urandom; op_b = $urandom; is_signed = 1'($urandom_range(0, 1));
    for (int c = 1; c <= W; c++) begin
      if (c == poke) begin
        start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
      end else begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("%s c%0d busy/stall/done", tag, c), {busy, stall, done}, 3'b110);
      next_cycle();
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    @(negedge clk);
    chk($sformatf("%s c%0d busy/stall/done", tag, W + 1), {busy, stall, done}, 3'b001);
    chk($sformatf("%s hi:lo", tag), {hi, lo}, exp);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    next_cycle();
    @(negedge clk);
    chk($sformatf("%s idle after done", tag), {busy, stall, done}, 3'b000);
    next_cycle();
  endtask

  initial begin
    int seen;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic        hw;
    logic        lw;
    logic [31:0] wd;

    reset = 1'b1; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    m_hi = '0; m_lo = '0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("reset busy/stall/done", {busy, stall, done}, 3'b000);
    chk("reset hi:lo", {hi, lo}, 64'h0);
    next_cycle();

    // Directed products
    run_op("t1 3x5 u",           32'd3,        32'd5,        1'b0, 64'h00000000_0000000F, 0);
    run_op("t2 -7x6 s",          32'hFFFFFFF9, 32'd6,        1'b1, 64'hFFFFFFFF_FFFFFFD6, 0);
    run_op("t3 ffxff u",         32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, 0);
    run_op("t3 -1x-1 s",         32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001, 0);
    run_op("t4 min x min s",     32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000, 0);
    run_op("t4 min x 1 s",       32'h80000000, 32'd1,        1'b1, 64'hFFFFFFFF_80000000, 0);
    run_op("t4 0 x ff u",        32'd0,        32'hFFFFFFFF, 1'b0, 64'h0, 0);

    // Start and writes during RUN are ignored
    run_op("t5 poke in run",     32'd1000,     32'd77,       1'b0, 64'd77000, 5);

    // MTHI in IDLE, LO untouched
    hi_we = 1'b1; wdata = 32'h12345678;
    next_cycle();
    hi_we = 1'b0;
    @(negedge clk);
    chk("t5 mthi hi:lo", {hi, lo}, {32'h12345678, m_lo});
    m_hi = 32'h12345678;
    next_cycle();

    // start + MTLO together: write dropped, multiply proceeds
    start = 1'b1; lo_we = 1'b1; wdata = 32'hCAFEF00D; op_a = 32'd4; op_b = 32'd5; is_signed = 1'b0;
    next_cycle();
    start = 1'b0; lo_we = 1'b0;
    @(negedge clk);
    chk("t5 start+mtlo hi:lo", {hi, lo}, {m_hi, m_lo});
    chk("t5 start+mtlo busy", {31'b0, busy}, 32'd1);
    for (int c = 2; c <= W + 1; c++) next_cycle();
    @(negedge clk);
    chk("t5 start+mtlo done", {31'b0, done}, 32'd1);
    chk("t5 start+mtlo result", {hi, lo}, 64'd20);
    next_cycle();
    next_cycle();

    // Reset in RUN cycle 15
    start = 1'b1; op_a = 32'd7; op_b = 32'd9; is_signed = 1'b0;
    next_cycle();
    start = 1'b0;
    for (int c = 2; c <= 15; c++) next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("t6 after reset busy/stall/done", {busy, stall, done}, 3'b000);
    chk("t6 after reset hi:lo", {hi, lo}, 64'h0);
    m_hi = '0; m_lo = '0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("t6 no done pulse", 64'(seen), 64'd0);
    next_cycle();
    run_op("t6 2x3 after reset", 32'd2, 32'd3, 1'b0, 64'd6, 0);

    // Randomized multiplies interleaved with random MTHI/MTLO writes
    for (int i = 0; i < 20; i++) begin
      hw = 1'($urandom_range(0, 1));
      lw = 1'($urandom_range(0, 1));
      wd = $urandom;
      hi_we = hw; lo_we = lw; wdata = wd;
      next_cycle();
      hi_we = 1'b0; lo_we = 1'b0;
      if (hw) m_hi = wd;
      if (lw) m_lo = wd;
      @(negedge clk);
      chk($sformatf("rnd%0d mt hi:lo", i), {hi, lo}, {m_hi, m_lo});
      next_cycle();

      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: a = 32'h0;
        1: a = 32'h80000000;
        2: b = 32'hFFFFFFFF;
        3: b = 32'h80000000;
        default: ;
      endcase
      s = 1'($urandom_range(0, 1));
      run_op($sformatf("rnd%0d %h*%h s%0d", i, a, b, s), a, b, s, ref_mul(a, b, s),
             int'($urandom_range(0, W)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
